bcd_xs3_seq: RTL and testbench

Multi-digit BCD-to-excess-3 sequencer. It accepts a packed DIGITS-wide BCD word on a start pulse and walks the digits LSB-first through a single shared 4-bit excess-3 conversion stage. Results collect in an output register and completion is signalled with a one-cycle done pulse. The block sits between a BCD source (counter/keypad decoder) and excess-3 consumers (self-complementing arithmetic), so one converter serves words of any width.

---
 rtl/bcd_xs3_seq_if.sv | 24 ++
 rtl/bcd_xs3_seq.sv | 108 ++++++++++
 tb/tb_bcd_xs3_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_xs3_seq_if.sv
// Handshake bundle between a BCD source and the bcd_xs3_seq converter.
// Handshake: start is a request that is taken only while idle. The result is
// valid on the single cycle that done is high, and it stays held until the
// next accepted start.
interface bcd_xs3_seq_if #(parameter int DIGITS = 4);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   xs3_out;
  logic [DIGITS-1:0]     err_mask;
  logic                  err;
  logic [1:0]            state_dbg;

  modport master (
    output start, bcd_in,
    input  busy, done, xs3_out, err_mask, err, state_dbg
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, xs3_out, err_mask, err, state_dbg
  );
endinterface

// File: rtl/bcd_xs3_seq.sv
// Multi-digit BCD to excess-3 sequencer. The digits of a word pass LSB-first
// through one shared 4-bit conversion stage, one digit per cycle.
module bcd_xs3_seq #(
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  bcd_xs3_seq_if.slave   bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   xs3_q, xs3_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [3:0]            cur_digit;
  logic                  last_digit;

  assign last_digit = (idx_q == IW'(DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    xs3_d     = xs3_q;
    mask_d    = mask_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cur_digit = word_q[{idx_q, 2'b00} +: 4];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          word_d  = bus.bcd_in;
          idx_d   = '0;
          xs3_d   = '0;
          mask_d  = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        // Non-BCD digits leave a zero slot and raise their error flag.
        if (cur_digit <= 4'd9) begin
          xs3_d[{idx_q, 2'b00} +: 4] = cur_digit + 4'd3;
        end else begin
          xs3_d[{idx_q, 2'b00} +: 4] = 4'h0;
          mask_d[idx_q]              = 1'b1;
          err_d                      = 1'b1;
        end
        if (last_digit) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      xs3_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      xs3_q   <= xs3_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.xs3_out   = xs3_q;
  assign bus.err_mask  = mask_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Bench for bcd_xs3_seq: a four-digit instance driven with directed and random
// words, plus a one-digit instance for the single-digit case.
module tb_bcd_xs3_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;
  int   overlap_cnt;
  int   exp_done;

  bcd_xs3_seq_if #(.DIGITS(4)) if4 ();
  bcd_xs3_seq_if #(.DIGITS(1)) if1 ();

  bcd_xs3_seq #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  bcd_xs3_seq #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mid-cycle monitors: count done pulses and any busy/done overlap.
  always @(negedge clk) begin
    if (!rst && if4.done) done_cnt++;
    if (if4.busy && if4.done) overlap_cnt++;
    if (if1.busy && if1.done) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every digit maps independently to digit+3, or to 0 with a flag.
  function automatic void model(input logic [15:0] w, output logic [15:0] x,
                                output logic [3:0] m);
    int d;
    x = '0;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'((w >> (4 * i)) & 16'hF);
      if (d <= 9) x = x | (16'(d + 3) << (4 * i));
      else        m[i] = 1'b1;
    end
  endfunction

  // Drives one word and checks it cycle by cycle; ends at edge k+5 (back in
  // IDLE), so an immediate further call meets the minimum start period.
  task automatic run_word(input logic [15:0] w, input string tag);
    logic [15:0] ex;
    logic [3:0]  em;
    model(w, ex, em);
    if4.bcd_in = w;
    if4.start  = 1'b1;
    tick();
    exp_done++;
    if4.start  = 1'b0;
    if4.bcd_in = 16'($urandom);
    chk({tag, ".busy_k"}, 64'(if4.busy), 64'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, ".busy_mid"}, 64'({if4.busy, if4.done}), 64'b10);
    end
    tick();
    chk({tag, ".done"}, 64'({if4.busy, if4.done}), 64'b01);
    chk({tag, ".xs3"}, 64'(if4.xs3_out), 64'(ex));
    chk({tag, ".mask"}, 64'(if4.err_mask), 64'(em));
    chk({tag, ".err"}, 64'(if4.err), 64'(em != 4'b0));
    tick();
    chk({tag, ".after"}, 64'({if4.busy, if4.done, if4.state_dbg}), 64'b0000);
    chk({tag, ".hold"}, 64'({if4.xs3_out, if4.err_mask, if4.err}), 64'({ex, em, em != 4'b0}));
  endtask

  initial begin
    logic [15:0] w;
    checks      = 0;
    failures    = 0;
    done_cnt    = 0;
    overlap_cnt = 0;
    exp_done    = 0;
    rst         = 1'b1;
    if4.start   = 1'b0;
    if4.bcd_in  = '0;
    if1.start   = 1'b0;
    if1.bcd_in  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and quiet idle.
    chk("reset.outs", 64'({if4.busy, if4.done, if4.xs3_out, if4.err_mask, if4.err}), 64'd0);
    chk("reset.state", 64'(if4.state_dbg), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.outs", 64'({if4.busy, if4.done, if4.xs3_out, if4.err_mask, if4.err}), 64'd0);
    end

    // Directed words, back-to-back at minimum period where consecutive.
    run_word(16'h1234, "w1234");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w1234.idle_hold", 64'({if4.busy, if4.xs3_out}), 64'({1'b0, 16'h4567}));
    end
    run_word(16'h0909, "w0909");
    run_word(16'h12A4, "w12A4");

    // A start pulse during conversion is ignored.
    if4.bcd_in = 16'h9999;
    if4.start  = 1'b1;
    tick();
    exp_done++;
    if4.start = 1'b0;
    tick();
    if4.start  = 1'b1;
    if4.bcd_in = 16'h0000;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    chk("ign.done", 64'({if4.done, if4.xs3_out, if4.err}), 64'({1'b1, 16'hCCCC, 1'b0}));
    tick();
    tick();
    tick();
    chk("ign.no_second", 64'({if4.busy, if4.done, if4.xs3_out}), 64'({2'b00, 16'hCCCC}));

    // Reset mid-conversion discards the word.
    if4.bcd_in = 16'h5678;
    if4.start  = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid.outs", 64'({if4.busy, if4.done, if4.xs3_out, if4.err_mask, if4.err}), 64'd0);
    chk("rst_mid.state", 64'(if4.state_dbg), 64'd0);
    // Reset wins over a simultaneous start.
    if4.start = 1'b1;
    tick();
    chk("rst_vs_start", 64'({if4.busy, if4.state_dbg}), 64'd0);
    if4.start = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid.no_done", 64'({if4.busy, if4.done}), 64'd0);
    end
    run_word(16'h0001, "w0001");

    // Random words, a fraction forced to be all-valid BCD.
    for (int n = 0; n < 24; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_word(w, "rand");
    end
    run_word(16'hFFFF, "wFFFF");
    run_word(16'h0000, "w0000");

    // Single-digit build.
    if1.bcd_in = 4'hF;
    if1.start  = 1'b1;
    tick();
    if1.start  = 1'b0;
    if1.bcd_in = 4'h2;
    chk("d1.busy", 64'({if1.busy, if1.done}), 64'b10);
    tick();
    chk("d1.done", 64'({if1.busy, if1.done, if1.xs3_out, if1.err_mask, if1.err}),
        64'({2'b01, 4'h0, 1'b1, 1'b1}));
    tick();
    chk("d1.after", 64'({if1.busy, if1.done, if1.state_dbg}), 64'd0);
    if1.bcd_in = 4'h9;
    if1.start  = 1'b1;
    tick();
    if1.start = 1'b0;
    tick();
    chk("d1.nine", 64'({if1.done, if1.xs3_out, if1.err_mask, if1.err}),
        64'({1'b1, 4'hC, 1'b0, 1'b0}));
    tick();

    chk("done_pulses", 64'(done_cnt), 64'(exp_done));
    chk("busy_done_overlap", 64'(overlap_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
